i2s_adc_rx: RTL and testbench



---
 rtl/i2s_adc_rx.sv | 173 +++++++++++++++++
 tb/tb_i2s_adc_rx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_adc_rx.sv
// I2S ADC capture: synchronises BCLK/LRCK/DATA into clk_48M, assembles {left,right}
// pairs and writes one word per stereo frame into the ADC FIFO, with debug flags.
module i2s_adc_rx #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_48M,
  input  logic                reset,
  input  logic                enable,
  input  logic                adc_bclk,
  input  logic                adc_lrck,
  input  logic                adc_dat,
  input  logic                fifo_full,
  output logic                fifo_wr_en,
  output logic [2*DATA_W-1:0] fifo_wr_data,
  output logic [15:0]         frame_cnt,
  output logic                overflow,
  output logic                frame_err,
  input  logic                clear_flags
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  localparam logic [1:0] ST_WAIT  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_PAD   = 2'd2;

  logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
  logic [SYNC_STAGES-1:0] lrck_sync_q, lrck_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q,  dat_sync_d;
  logic                   bclk_prev_q, bclk_prev_d;
  logic                   lrck_prev_q, lrck_prev_d;

  logic [1:0]          state_q, state_d;
  logic                chan_q, chan_d;
  logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_W-2:0]   sreg_q, sreg_d;
  logic [DATA_W-1:0]   left_hold_q, left_hold_d;
  logic                left_valid_q, left_valid_d;
  logic                wr_en_q, wr_en_d;
  logic [2*DATA_W-1:0] wr_data_q, wr_data_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                overflow_q, overflow_d;
  logic                frame_err_q, frame_err_d;

  logic              bclk_s, lrck_s, dat_s;
  logic              bclk_rise, boundary;
  logic [DATA_W-1:0] shifted;

  always_comb begin
    bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], adc_bclk};
    lrck_sync_d = {lrck_sync_q[SYNC_STAGES-2:0], adc_lrck};
    dat_sync_d  = {dat_sync_q[SYNC_STAGES-2:0],  adc_dat};
    bclk_s      = bclk_sync_q[SYNC_STAGES-1];
    lrck_s      = lrck_sync_q[SYNC_STAGES-1];
    dat_s       = dat_sync_q[SYNC_STAGES-1];
    bclk_prev_d = bclk_s;
    bclk_rise   = bclk_s & ~bclk_prev_q;
    boundary    = bclk_rise & (lrck_s != lrck_prev_q);
    shifted     = {sreg_q, dat_s};
  end

  always_comb begin
    state_d      = state_q;
    chan_d       = chan_q;
    bit_cnt_d    = bit_cnt_q;
    sreg_d       = sreg_q;
    left_hold_d  = left_hold_q;
    left_valid_d = left_valid_q;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    frame_cnt_d  = frame_cnt_q + {15'd0, wr_en_q};
    overflow_d   = overflow_q & ~clear_flags;
    frame_err_d  = frame_err_q & ~clear_flags;
    lrck_prev_d  = bclk_rise ? lrck_s : lrck_prev_q;

    if (!enable) begin
      state_d      = ST_WAIT;
      left_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (boundary && !lrck_s) begin
            state_d   = ST_SHIFT;
            chan_d    = 1'b0;
            bit_cnt_d = '0;
          end
        end
        ST_SHIFT: begin
          // A boundary before DATA_W bits means the channel was short
          if (boundary) begin
            frame_err_d  = 1'b1;
            left_valid_d = 1'b0;
            chan_d       = lrck_s;
            bit_cnt_d    = '0;
          end else if (bclk_rise) begin
            sreg_d    = shifted[DATA_W-2:0];
            bit_cnt_d = bit_cnt_q + CW'(1);
            if (bit_cnt_q == LAST_BIT) begin
              state_d = ST_PAD;
              if (!chan_q) begin
                left_hold_d  = shifted;
                left_valid_d = 1'b1;
              end else if (left_valid_q) begin
                left_valid_d = 1'b0;
                if (!fifo_full) begin
                  wr_en_d   = 1'b1;
                  wr_data_d = {left_hold_q, shifted};
                end else begin
                  overflow_d = 1'b1;
                end
              end
            end
          end
        end
        ST_PAD: begin
          if (boundary) begin
            state_d   = ST_SHIFT;
            chan_d    = lrck_s;
            bit_cnt_d = '0;
          end
        end
        default: state_d = ST_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk_48M) begin
    if (reset) begin
      bclk_sync_q  <= '0;
      lrck_sync_q  <= '0;
      dat_sync_q   <= '0;
      bclk_prev_q  <= 1'b0;
      lrck_prev_q  <= 1'b0;
      state_q      <= ST_WAIT;
      chan_q       <= 1'b0;
      bit_cnt_q    <= '0;
      sreg_q       <= '0;
      left_hold_q  <= '0;
      left_valid_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      frame_cnt_q  <= '0;
      overflow_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      bclk_sync_q  <= bclk_sync_d;
      lrck_sync_q  <= lrck_sync_d;
      dat_sync_q   <= dat_sync_d;
      bclk_prev_q  <= bclk_prev_d;
      lrck_prev_q  <= lrck_prev_d;
      state_q      <= state_d;
      chan_q       <= chan_d;
      bit_cnt_q    <= bit_cnt_d;
      sreg_q       <= sreg_d;
      left_hold_q  <= left_hold_d;
      left_valid_q <= left_valid_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      frame_cnt_q  <= frame_cnt_d;
      overflow_q   <= overflow_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign frame_cnt    = frame_cnt_q;
  assign overflow     = overflow_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Bench for i2s_adc_rx: drives I2S slots and checks writes against a slot-level model.
`timescale 1ns/1ps
module tb_i2s_adc_rx;

  localparam int DW = 16;
  localparam int SS = 2;
  localparam int H  = 85;  // BCLK half period in ns, never on a clk_48M edge

  logic        clk_48M = 1'b0;
  logic        reset, enable, adc_bclk, adc_lrck, adc_dat, fifo_full, clear_flags;
  logic        fifo_wr_en;
  logic [31:0] fifo_wr_data;
  logic [15:0] frame_cnt;
  logic        overflow, frame_err;

  always #10 clk_48M = ~clk_48M;

  i2s_adc_rx #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
    .clk_48M(clk_48M), .reset(reset), .enable(enable),
    .adc_bclk(adc_bclk), .adc_lrck(adc_lrck), .adc_dat(adc_dat),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .frame_cnt(frame_cnt), .overflow(overflow), .frame_err(frame_err),
    .clear_flags(clear_flags)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Slot-level model state
  logic [31:0] exp_q[$];
  bit          m_synced, m_lv, m_prev, m_ovf, m_ferr;
  logic [15:0] m_cnt, m_lhold;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk_48M) begin
    if (fifo_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got strobe with data 0x%0h expected no strobe", fifo_wr_data);
      end else begin
        chk("wr_data", fifo_wr_data, exp_q.pop_front());
      end
    end
  end

  task automatic model_reset();
    m_synced = 0; m_lv = 0; m_prev = 0; m_ovf = 0; m_ferr = 0;
    m_cnt = '0; m_lhold = '0;
  endtask

  // One slot = n BCLK periods at LRCK=c; first period is the boundary bit,
  // the following DW periods carry the word MSB first.
  task automatic model_slot(input bit c, input logic [15:0] w, input int n,
                            input bit en0, input bit full, input bit rst);
    bit bnd;
    bnd = (c != m_prev);
    m_prev = c;
    if (rst) begin
      model_reset();
      m_prev = c;
      return;
    end
    if (!en0) begin
      m_synced = 0;
      m_lv = 0;
      return;
    end
    if (!m_synced) begin
      if (bnd && !c) m_synced = 1;
      else return;
    end
    if (n - 1 < DW) begin
      m_ferr = 1;
      m_lv = 0;
    end else if (!c) begin
      m_lhold = w;
      m_lv = 1;
    end else if (m_lv) begin
      m_lv = 0;
      if (!full) begin
        exp_q.push_back({m_lhold, w});
        m_cnt++;
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic send_slot(input bit c, input logic [15:0] w, input int n,
                           input int en_at = -1, input bit en_val = 1'b1,
                           input int rst_at = -1, input bit lat = 1'b0);
    bit  en0;
    time t0;
    en0 = (en_at == 0) ? en_val : enable;
    model_slot(c, w, n, en0, fifo_full, rst_at >= 0);
    for (int i = 0; i < n; i++) begin
      adc_lrck = c;
      if (i >= 1 && i <= DW) adc_dat = w[DW-i];
      else adc_dat = 1'($urandom);
      if (i == en_at) enable = en_val;
      if (i == rst_at) begin
        reset = 1'b1;
        @(posedge clk_48M);
        #1;
        chk("rst_mid_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        chk("rst_mid_wr_data", fifo_wr_data, 32'd0);
        chk("rst_mid_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("rst_mid_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_mid_frame_err", {31'd0, frame_err}, 32'd0);
        repeat (2) @(posedge clk_48M);
        reset = 1'b0;
        #3;
      end
      #H;
      adc_bclk = 1'b1;
      t0 = $time;
      if (lat && i == DW) begin
        repeat (SS) @(posedge clk_48M);
        #1;
        chk("strobe_early", {31'd0, fifo_wr_en}, 32'd0);
        @(posedge clk_48M);
        #1;
        chk("strobe_latency", {31'd0, fifo_wr_en}, 32'd1);
      end
      #(t0 + H - $time);
      adc_bclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input bit lat = 1'b0);
    send_slot(1'b0, l, 32);
    send_slot(1'b1, r, 32, -1, 1'b1, -1, lat);
  endtask

  task automatic checkpoint(input string tag);
    chk({tag, "_pending_writes"}, exp_q.size(), 32'd0);
    chk({tag, "_frame_cnt"}, {16'd0, frame_cnt}, {16'd0, m_cnt});
    chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, m_ovf});
    chk({tag, "_frame_err"}, {31'd0, frame_err}, {31'd0, m_ferr});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; adc_bclk = 1'b0; adc_lrck = 1'b1; adc_dat = 1'b0;
    fifo_full = 1'b0; clear_flags = 1'b0;
    model_reset();

    // Reset held with BCLK toggling
    repeat (3) begin
      @(posedge clk_48M);
      #3 adc_bclk = ~adc_bclk;
    end
    @(posedge clk_48M);
    #1;
    chk("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    chk("rst_wr_data", fifo_wr_data, 32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    reset = 1'b0;
    adc_bclk = 1'b0;
    #2;
    enable = 1'b1;

    // Short right preamble so the first left slot is a 1->0 boundary
    send_slot(1'b1, 16'h0000, 8);

    // Nominal frames
    send_frame(16'hA5C3, 16'h1234, 1'b1);
    chk("nominal_cnt1", {16'd0, frame_cnt}, 32'd1);
    send_frame(16'hA5C3, 16'h1234);
    chk("nominal_cnt2", {16'd0, frame_cnt}, 32'd2);
    send_frame(16'hA5C3, 16'h1234);
    checkpoint("nominal");
    chk("nominal_cnt3", {16'd0, frame_cnt}, 32'd3);
    chk("nominal_data", fifo_wr_data, 32'hA5C31234);

    // Disable, then enable in the middle of a right slot
    enable = 1'b0;
    m_synced = 0; m_lv = 0;
    #100;
    send_slot(1'b0, 16'h1111, 32);
    send_slot(1'b1, 16'h2222, 32, 5, 1'b1);
    send_frame(16'h0F0F, 16'hF00D);
    checkpoint("enable");
    chk("enable_cnt", {16'd0, frame_cnt}, 32'd4);
    chk("enable_data", fifo_wr_data, 32'h0F0FF00D);

    // FIFO full during a completion, then normal, then clear
    fifo_full = 1'b1;
    send_frame(16'h1357, 16'h2468);
    fifo_full = 1'b0;
    checkpoint("full");
    chk("full_overflow", {31'd0, overflow}, 32'd1);
    chk("full_cnt", {16'd0, frame_cnt}, 32'd4);
    send_frame(16'hBEEF, 16'hCAFE);
    checkpoint("after_full");
    @(posedge clk_48M);
    #3 clear_flags = 1'b1;
    @(posedge clk_48M);
    #3 clear_flags = 1'b0;
    m_ovf = 0;
    chk("clear_overflow", {31'd0, overflow}, 32'd0);

    // Short left slot (LRCK toggles after 10 BCLKs)
    send_slot(1'b0, 16'hDEAD, 10);
    send_slot(1'b1, 16'h5555, 32);
    checkpoint("short");
    chk("short_frame_err", {31'd0, frame_err}, 32'd1);
    chk("short_cnt", {16'd0, frame_cnt}, 32'd5);
    send_frame(16'h7E57, 16'h0042);
    send_frame(16'h0001, 16'h8000);
    checkpoint("after_short");

    // Reset in the middle of a left slot
    send_slot(1'b0, 16'h3C3C, 32, -1, 1'b1, 8);
    send_slot(1'b1, 16'h9999, 32);
    checkpoint("after_reset");
    send_frame(16'h6C6C, 16'h9393);
    checkpoint("resync");
    chk("resync_cnt", {16'd0, frame_cnt}, 32'd1);
    chk("resync_data", fifo_wr_data, 32'h6C6C9393);

    #200;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
